// File: rtl/lcd_spi_pkg.sv
// Shared definitions for the ST7735 byte-level SPI writer: FSM states,
// default timing parameters and the layout of the 9-bit {dc, byte} word.
package lcd_spi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_DONE,
        ST_GAP
    } state_e;

    localparam int DEF_CLK_DIV    = 2;
    localparam int DEF_GAP_CYCLES = 4;

    localparam int WORD_W  = 9;
    localparam int DC_BIT  = 8;
    localparam int MSB_BIT = 7;

    // Phase 16 is the hold phase; 14 is the last phase that shifts a new bit.
    localparam logic [4:0] PH_HOLD       = 5'd16;
    localparam logic [4:0] PH_LAST_SHIFT = 5'd14;

endpackage

// File: rtl/lcd_spi_tick.sv
// SCK half-period counter: pulses tick_o for one cycle every CLK_DIV cycles
// while running, and holds at zero while clr_i is high.
module lcd_spi_tick
    import lcd_spi_pkg::*;
#(
    parameter int CLK_DIV = DEF_CLK_DIV
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    output logic tick_o
);

    localparam logic [7:0] CNT_LAST = 8'(CLK_DIV - 1);

    logic [7:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q + 8'd1;
        if (clr_i || cnt_q == CNT_LAST) begin
            cnt_d = 8'd0;
        end
    end

    assign tick_o = !clr_i && (cnt_q == CNT_LAST);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/lcd_spi_write.sv
// ST7735 SPI mode-0 byte writer for 9-bit {dc, byte} words with a post-byte gap.
// Optional LCD_SPI_CS_KEEP_EN keeps chip select low across back-to-back bytes.
module lcd_spi_write
    import lcd_spi_pkg::*;
#(
    parameter int CLK_DIV    = DEF_CLK_DIV,
    parameter int GAP_CYCLES = DEF_GAP_CYCLES
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic [WORD_W-1:0] data,
    input  logic              en_write,
    output logic              wr_done,
    output logic              busy,
    output logic              lcd_sclk,
    output logic              lcd_mosi,
    output logic              lcd_cs_n,
    output logic              lcd_dc
);

    // GAP holds GAP_CYCLES-1 cycles; the IDLE sampling cycle completes the gap.
    localparam logic [15:0] GAP_LAST = 16'(GAP_CYCLES - 2);

    state_e      state_q, state_d;
    logic [4:0]  phase_q, phase_d;
    logic [4:0]  ph_next;
    logic [15:0] gap_q, gap_d;
    logic [7:0]  shreg_q, shreg_d;
    logic        sclk_q, sclk_d;
    logic        mosi_q, mosi_d;
    logic        cs_n_q, cs_n_d;
    logic        dc_q, dc_d;
    logic        done_q, done_d;
    logic        busy_q, busy_d;
    logic        tick;

    lcd_spi_tick #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .clk_i  (sys_clk),
        .rst_i  (sys_rst),
        .clr_i  (state_q != ST_SHIFT),
        .tick_o (tick)
    );

    assign ph_next = phase_q + 5'd1;

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        gap_d   = gap_q;
        shreg_d = shreg_q;
        sclk_d  = sclk_q;
        mosi_d  = mosi_q;
        cs_n_d  = cs_n_q;
        dc_d    = dc_q;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!en_write) begin
                    cs_n_d = 1'b1;
                end
                if (en_write) begin
                    state_d = ST_SHIFT;
                    phase_d = 5'd0;
                    shreg_d = data[MSB_BIT:0];
                    dc_d    = data[DC_BIT];
                    cs_n_d  = 1'b0;
                    mosi_d  = data[MSB_BIT];
                    sclk_d  = 1'b0;
                end
            end

            ST_SHIFT: begin
                if (tick) begin
                    if (phase_q == PH_HOLD) begin
                        state_d = ST_DONE;
                        phase_d = 5'd0;
                        done_d  = 1'b1;
                        mosi_d  = 1'b0;
                        sclk_d  = 1'b0;
`ifdef LCD_SPI_CS_KEEP_EN
                        cs_n_d  = 1'b0;
`else
                        cs_n_d  = 1'b1;
`endif
                    end else begin
                        phase_d = ph_next;
                        if (ph_next[0]) begin
                            sclk_d = 1'b1;
                        end else begin
                            sclk_d = 1'b0;
                            if (ph_next <= PH_LAST_SHIFT) begin
                                shreg_d = shreg_q << 1;
                                mosi_d  = shreg_d[MSB_BIT];
                            end
                        end
                    end
                end
            end

            ST_DONE: begin
                state_d = ST_GAP;
                gap_d   = 16'd0;
            end

            ST_GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = ST_IDLE;
                    gap_d   = 16'd0;
`ifdef LCD_SPI_CS_KEEP_EN
                    if (!en_write) begin
                        cs_n_d = 1'b1;
                    end
`else
                    cs_n_d = 1'b1;
`endif
                end else begin
                    gap_d = gap_q + 16'd1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q <= ST_IDLE;
            phase_q <= 5'd0;
            gap_q   <= 16'd0;
            shreg_q <= 8'd0;
            sclk_q  <= 1'b0;
            mosi_q  <= 1'b0;
            cs_n_q  <= 1'b1;
            dc_q    <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            gap_q   <= gap_d;
            shreg_q <= shreg_d;
            sclk_q  <= sclk_d;
            mosi_q  <= mosi_d;
            cs_n_q  <= cs_n_d;
            dc_q    <= dc_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign wr_done  = done_q;
    assign busy     = busy_q;
    assign lcd_sclk = sclk_q;
    assign lcd_mosi = mosi_q;
    assign lcd_cs_n = cs_n_q;
    assign lcd_dc   = dc_q;

endmodule

// File: tb/tb_lcd_spi_write.sv
// Bench for lcd_spi_write: two instances (CLK_DIV=2 and CLK_DIV=1) checked
// cycle by cycle against a timeline model of the byte waveform.
module tb_lcd_spi_write;

    localparam int DIV_A = 2;
    localparam int DIV_B = 1;
    localparam int GAP   = 4;
`ifdef LCD_SPI_CS_KEEP_EN
    localparam bit KEEP = 1'b1;
`else
    localparam bit KEEP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [8:0] dat [2];
    logic [1:0] en;
    logic [1:0] done, bsy, sclk, mosi, csn, dc;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    lcd_spi_write #(.CLK_DIV(DIV_A), .GAP_CYCLES(GAP)) dut_a (
        .sys_clk (clk), .sys_rst (rst), .data (dat[0]), .en_write (en[0]),
        .wr_done (done[0]), .busy (bsy[0]), .lcd_sclk (sclk[0]),
        .lcd_mosi (mosi[0]), .lcd_cs_n (csn[0]), .lcd_dc (dc[0])
    );

    lcd_spi_write #(.CLK_DIV(DIV_B), .GAP_CYCLES(GAP)) dut_b (
        .sys_clk (clk), .sys_rst (rst), .data (dat[1]), .en_write (en[1]),
        .wr_done (done[1]), .busy (bsy[1]), .lcd_sclk (sclk[1]),
        .lcd_mosi (mosi[1]), .lcd_cs_n (csn[1]), .lcd_dc (dc[1])
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    function automatic int div_of(input int u);
        return (u == 0) ? DIV_A : DIV_B;
    endfunction

    // Runs one byte whose E0 is the next posedge; ends at the IDLE sample.
    task automatic run_byte(input int u, input logic [8:0] w, input bit stream,
                            input logic [8:0] nw, input int drop_k, input bit scramble);
        int d, len, p, b, nrise, ndone;
        logic [7:0] rx;
        logic prev_sclk, e_sclk, e_mosi, e_cs, e_done, e_busy;
        d = div_of(u);
        len = 17 * d + GAP;
        rx = 8'd0;
        nrise = 0;
        ndone = 0;
        prev_sclk = 1'b0;
        for (int k = 0; k <= len; k++) begin
            @(negedge clk);
            if (k < 17 * d) begin
                p = k / d;
                b = (p / 2 > 7) ? 7 : p / 2;
                e_sclk = (p % 2 == 1);
                e_mosi = w[7-b];
                e_cs = 1'b0;
                e_done = 1'b0;
                e_busy = 1'b1;
            end else if (k < len) begin
                e_sclk = 1'b0;
                e_mosi = 1'b0;
                e_done = (k == 17 * d);
                e_busy = 1'b1;
                e_cs = !KEEP;
            end else begin
                e_sclk = 1'b0;
                e_mosi = 1'b0;
                e_done = 1'b0;
                e_busy = 1'b0;
                e_cs = KEEP ? !stream : 1'b1;
            end
            chk("sclk", 32'(sclk[u]), 32'(e_sclk));
            chk("mosi", 32'(mosi[u]), 32'(e_mosi));
            chk("cs_n", 32'(csn[u]), 32'(e_cs));
            chk("wr_done", 32'(done[u]), 32'(e_done));
            chk("busy", 32'(bsy[u]), 32'(e_busy));
            chk("dc", 32'(dc[u]), 32'(w[8]));
            if (sclk[u] && !prev_sclk) begin
                rx = {rx[6:0], mosi[u]};
                nrise++;
            end
            prev_sclk = sclk[u];
            ndone += int'(done[u]);
            if (!stream && k >= drop_k) en[u] = 1'b0;
            if (scramble && !stream && k >= 1) dat[u] = 9'($urandom);
            if (stream && k == 17 * d + 3) dat[u] = nw;
        end
        chk("rx_byte", 32'(rx), 32'(w[7:0]));
        chk("rx_edges", 32'(nrise), 32'd8);
        chk("done_pulses", 32'(ndone), 32'd1);
    endtask

    initial begin
        int n, dk, cnt;
        logic [8:0] ws [3];
        bit sc;
        rst = 1'b1;
        en = 2'b00;
        dat[0] = 9'h000;
        dat[1] = 9'h000;
        repeat (3) @(negedge clk);
        for (int u = 0; u < 2; u++) begin
            chk("rst_cs_n", 32'(csn[u]), 32'd1);
            chk("rst_sclk", 32'(sclk[u]), 32'd0);
            chk("rst_mosi", 32'(mosi[u]), 32'd0);
            chk("rst_dc", 32'(dc[u]), 32'd0);
            chk("rst_done", 32'(done[u]), 32'd0);
            chk("rst_busy", 32'(bsy[u]), 32'd0);
        end
        rst = 1'b0;
        @(negedge clk);

        // Single command byte
        dat[0] = 9'h02A;
        en[0] = 1'b1;
        run_byte(0, 9'h02A, 1'b0, 9'h000, 0, 1'b0);

        // Back-to-back data stream with en_write held high
        dat[0] = 9'h1A5;
        en[0] = 1'b1;
        run_byte(0, 9'h1A5, 1'b1, 9'h15A, 0, 1'b0);
        run_byte(0, 9'h15A, 1'b1, 9'h1FF, 0, 1'b0);
        run_byte(0, 9'h1FF, 1'b0, 9'h000, 3, 1'b0);

        // Fastest SCK
        dat[1] = 9'h080;
        en[1] = 1'b1;
        run_byte(1, 9'h080, 1'b0, 9'h000, 0, 1'b0);

        // en_write dropped mid-byte and data scrambled
        dat[0] = 9'h13C;
        en[0] = 1'b1;
        run_byte(0, 9'h13C, 1'b0, 9'h000, 5, 1'b1);
        cnt = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            cnt += int'(bsy[0]) + int'(done[0]);
        end
        chk("no_restart", 32'(cnt), 32'd0);

        // Reset in the middle of a byte
        dat[0] = 9'h0C3;
        en[0] = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            en[0] = 1'b0;
            if (k == 9) rst = 1'b1;
        end
        @(negedge clk);
        chk("abort_cs_n", 32'(csn[0]), 32'd1);
        chk("abort_sclk", 32'(sclk[0]), 32'd0);
        chk("abort_busy", 32'(bsy[0]), 32'd0);
        rst = 1'b0;
        cnt = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            cnt += int'(done[0]);
        end
        chk("abort_no_done", 32'(cnt), 32'd0);
        dat[0] = 9'h1E7;
        en[0] = 1'b1;
        run_byte(0, 9'h1E7, 1'b0, 9'h000, 0, 1'b0);

        // Randomized single bytes and short streams on both instances
        for (int it = 0; it < 10; it++) begin
            int u;
            u = int'($urandom_range(0, 1));
            n = int'($urandom_range(1, 3));
            for (int i = 0; i < 3; i++) ws[i] = 9'($urandom);
            dk = int'($urandom_range(0, 17 * div_of(u) + GAP - 1));
            sc = 1'($urandom);
            dat[u] = ws[0];
            en[u] = 1'b1;
            for (int i = 0; i < n; i++) begin
                if (i < n - 1) run_byte(u, ws[i], 1'b1, ws[i+1], 0, 1'b0);
                else run_byte(u, ws[i], 1'b0, 9'h000, dk, sc);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
